uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL provide parameter SYS_CLK_FREQ, default 16, comm_clk frequency in Hz.
REQ-002 The block SHALL provide parameter BAUD_RATE, default 1, line bit rate in bit/s.
REQ-003 The block SHALL provide parameter DATA_BITS, default 8, legal range 5..9, character width.
REQ-004 The block SHALL provide parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-005 The block SHALL provide parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 The block SHALL provide parameter FIFO_DEPTH, default 4, power of two, minimum 2.
REQ-007 comm_clk  input  1  the only clock; all logic rises on its posedge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 rx_serial  input  1  asynchronous serial line, idle high.
REQ-010 rx_data  output  DATA_BITS  head-of-FIFO character, LSB received first.
REQ-011 rx_valid  output  1  high while the FIFO is non-empty.
REQ-012 rx_ready  input  1  consumer accept; a pop occurs on cycles with rx_valid and rx_ready both high.
REQ-013 fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 framing_error, parity_error, overrun  output  1 each  one-cycle error pulses.

Function
REQ-015 CLKS_PER_BIT SHALL be SYS_CLK_FREQ/BAUD_RATE, integer division; values below 4 SHALL be rejected at elaboration.
REQ-016 rx_serial SHALL pass through a 2-flop synchronizer, reset value 1, before any use.
REQ-017 The FSM states SHALL be IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
- IDLE -> START on a synchronized falling edge; the bit counter is cleared.
- START samples at CLKS_PER_BIT/2 cycles: low -> DATA; high -> IDLE (false start, no pulse).
REQ-018 DATA SHALL sample every CLKS_PER_BIT cycles after the mid-start sample, shifting LSB first, for DATA_BITS samples, then go to PAR (PARITY != 0) or STOP.
REQ-019 PAR SHALL sample one bit and compare it with XOR of the data bits: XNOR for odd, XOR for even.
REQ-020 STOP SHALL sample STOP_BITS bits at bit spacing; any low sample flags a framing error.
REQ-021 A character with neither error SHALL be pushed into the FIFO one cycle after the final stop-bit sample, and the FSM SHALL return to IDLE.
REQ-022 An errored character SHALL be discarded, not pushed.
- Framing error takes priority; only framing_error pulses.
- Otherwise parity_error pulses, in the cycle the good character would have been pushed.
REQ-023 After a framing error the FSM SHALL enter WAIT_IDLE and stay there until the synchronized line is high, then go to IDLE; this makes a break condition produce exactly one framing_error pulse.
REQ-024 A push into a full FIFO SHALL be dropped, with overrun pulsed for one cycle, unless a pop occurs in the same cycle; a simultaneous pop and push at full SHALL accept the push.
REQ-025 The FIFO SHALL be first-word-fall-through.
- rx_valid and rx_data update the cycle after a push into an empty FIFO.
- Simultaneous push and pop at empty SHALL not pop the new entry in that cycle.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL equal pushes minus pops, bounded 0..FIFO_DEPTH.
REQ-027 rx_data SHALL hold its value while rx_valid is high and rx_ready is low.

Reset
REQ-028 Reset SHALL force the following immediately, independent of comm_clk:
- FSM to IDLE, counters to 0, synchronizer flops to 1.
- FIFO empty: rx_valid=0, fifo_count=0, rx_data=0.
- All error pulses to 0.
REQ-029 A reset asserted mid-frame SHALL abandon the partial character; after release, reception SHALL restart only on a fresh falling edge.

Structure
REQ-030 A shared package uart_pkg SHALL hold the parity mode constants (PARITY_NONE/ODD/EVEN) and the FSM state encoding.
REQ-031 The FIFO SHALL be a separate sub-module uart_fifo, parameterised by WIDTH and DEPTH and sharing comm_clk and reset; everything else stays in uart_rx_param.

Verification
REQ-032 Defaults, send 0x08 at 160 ns per bit with rx_ready high -> one pop of rx_data 0x08, no error pulses.
REQ-033 Low glitch of 5 comm_clk cycles on rx_serial -> no push, no error pulses, FSM back in IDLE.
REQ-034 Send 0xA5 with the stop bit held low, then the line high -> exactly one framing_error pulse, fifo_count stays 0; then send 0x3C -> 0x3C received.
REQ-035 PARITY=2, send 0x07 with parity bit 0 -> parity_error pulse, no push; send 0x07 with parity bit 1 -> 0x07 received.
REQ-036 FIFO_DEPTH=4, rx_ready low, send 0x01..0x05 -> fifo_count=4, one overrun pulse on the fifth character; raise rx_ready -> pops 0x01, 0x02, 0x03, 0x04 in order.
REQ-037 Assert reset during DATA bit 3 of a character -> rx_valid=0 immediately, no push from the partial character; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice.
//   PARITY_*   : parity mode constants for the PARITY parameter
//   rx_state_t : receiver FSM state encoding
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PAR       = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO holding received characters.
//   comm_clk, reset : clock, asynchronous active-high reset
//   push, push_data : write strobe and character
//   pop_req         : consumer accept (pops only when not_empty)
//   head_data       : head entry, zero while empty
//   not_empty       : FIFO holds at least one entry
//   count           : occupancy 0..DEPTH
//   overrun         : one-cycle pulse when a push is dropped at full
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     comm_clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_req,
  output logic [WIDTH-1:0]         head_data,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign not_empty = (count != '0);
  assign full      = (count == (PW+1)'(DEPTH));
  assign pop       = pop_req & not_empty;
  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign push_ok   = push & (~full | pop);
  assign head_data = not_empty ? mem[rd_ptr] : '0;

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge comm_clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push & full & ~pop;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; head_data is masked to zero while
  // empty, so stale contents are never visible and the array maps to plain RAM.
  always_ff @(posedge comm_clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with error detection and an output FIFO.
//   comm_clk, reset : clock, asynchronous active-high reset
//   rx_serial       : asynchronous serial line, idle high
//   rx_data         : head-of-FIFO character, LSB received first
//   rx_valid        : FIFO non-empty
//   rx_ready        : consumer accept
//   fifo_count      : FIFO occupancy
//   framing_error, parity_error, overrun : one-cycle error pulses
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 16,
  parameter int BAUD_RATE    = 1,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          comm_clk,
  input  logic                          reset,
  input  logic                          rx_serial,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_error,
  output logic                          parity_error,
  output logic                          overrun
);

  localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 4) begin : g_chk_cpb
    $error("uart_rx_param: SYS_CLK_FREQ/BAUD_RATE must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_chk_par
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_rx_param: FIFO_DEPTH must be a power of two, at least 2");
  end

  rx_state_t            state, next_state;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0]     clk_cnt;
  logic [3:0]           bit_cnt;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad, stop_bad;
  logic                 push_q;

  logic fall, tick_half, tick_full, last_data, last_stop, frame_bad, exp_par;
  logic frame_clr, shift_en, par_en, stop_en, frame_done;

  // NOTE: every flop uses non-blocking assignments so that each stage of the
  // synchronizer samples the previous stage's pre-edge value.
  always_ff @(posedge comm_clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall      = rx_prev & ~rx_sync;
  assign tick_half = (clk_cnt == CNT_W'(HALF_BIT - 1));
  assign tick_full = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
  assign frame_bad = stop_bad | ~rx_sync;
  // Odd parity expects the XNOR of the data bits on the line, even the XOR.
  assign exp_par   = (PARITY == PARITY_ODD) ? ~^shift_reg : ^shift_reg;

  // FSM: state register
  always_ff @(posedge comm_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM: next-state logic
  // NOTE: next_state gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (fall) next_state = START;
      START:     if (tick_half) next_state = rx_sync ? IDLE : DATA;
      DATA:      if (tick_full && last_data)
                   next_state = (PARITY != PARITY_NONE) ? PAR : STOP;
      PAR:       if (tick_full) next_state = STOP;
      STOP:      if (tick_full && last_stop)
                   next_state = frame_bad ? WAIT_IDLE : IDLE;
      WAIT_IDLE: if (rx_sync) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // FSM: output (datapath control) logic
  always_comb begin
    frame_clr  = (state == IDLE);
    shift_en   = (state == DATA) && tick_full;
    par_en     = (state == PAR)  && tick_full;
    stop_en    = (state == STOP) && tick_full;
    frame_done = stop_en && last_stop;
  end

  always_ff @(posedge comm_clk or posedge reset) begin
    if (reset) begin
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      stop_idx      <= 1'b0;
      shift_reg     <= '0;
      par_bad       <= 1'b0;
      stop_bad      <= 1'b0;
      push_q        <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
    end else begin
      // Bit timer restarts on every state change and at each full bit period,
      // so data samples land one bit period after the mid-start sample.
      if (state != next_state || tick_full) clk_cnt <= '0;
      else                                  clk_cnt <= clk_cnt + CNT_W'(1);

      if (frame_clr) begin
        bit_cnt  <= '0;
        stop_idx <= 1'b0;
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end
      if (shift_en) begin
        shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
        bit_cnt   <= bit_cnt + 4'd1;
      end
      if (par_en)  par_bad <= (rx_sync != exp_par);
      if (stop_en) begin
        stop_idx <= ~stop_idx;
        stop_bad <= stop_bad | ~rx_sync;
      end

      // Results are registered so push and error pulses appear one cycle
      // after the final stop sample; framing error masks parity error.
      push_q        <= frame_done & ~frame_bad & ~par_bad;
      framing_error <= frame_done & frame_bad;
      parity_error  <= frame_done & ~frame_bad & par_bad;
    end
  end

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .comm_clk  (comm_clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (shift_reg),
    .pop_req   (rx_ready),
    .head_data (rx_data),
    .not_empty (rx_valid),
    .count     (fifo_count),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: a default instance and an
// even-parity instance, driven by serial frames built bit by bit.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       comm_clk = 1'b0;
  logic       reset    = 1'b0;
  logic       line0 = 1'b1, line1 = 1'b1;
  logic       ready0 = 1'b0, ready1 = 1'b0;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic [2:0] cnt0, cnt1;
  logic       fe0_p, pe0_p, ov0_p, fe1_p, pe1_p, ov1_p;

  always #5 comm_clk = ~comm_clk;

  uart_rx_param u_dut (
    .comm_clk (comm_clk), .reset (reset), .rx_serial (line0),
    .rx_data (data0), .rx_valid (valid0), .rx_ready (ready0),
    .fifo_count (cnt0), .framing_error (fe0_p), .parity_error (pe0_p),
    .overrun (ov0_p)
  );

  uart_rx_param #(.PARITY(PARITY_EVEN)) u_par (
    .comm_clk (comm_clk), .reset (reset), .rx_serial (line1),
    .rx_data (data1), .rx_valid (valid1), .rx_ready (ready1),
    .fifo_count (cnt1), .framing_error (fe1_p), .parity_error (pe1_p),
    .overrun (ov1_p)
  );

  int tests_run = 0, tests_failed = 0;
  int fe0 = 0, pe0 = 0, ov0 = 0, fe1 = 0, pe1 = 0, ov1 = 0;
  logic [7:0] q0[$], q1[$];

  // Observe pops and pulses mid-cycle, away from the active edge.
  always @(negedge comm_clk) begin
    if (!reset) begin
      if (valid0 && ready0) q0.push_back(data0);
      if (valid1 && ready1) q1.push_back(data1);
      if (fe0_p) fe0++;
      if (pe0_p) pe0++;
      if (ov0_p) ov0++;
      if (fe1_p) fe1++;
      if (pe1_p) pe1++;
      if (ov1_p) ov1++;
    end
  end

  task automatic set_line(input int inst, input logic v);
    if (inst == 0) line0 = v;
    else           line1 = v;
  endtask

  task automatic hold_line(input int inst, input logic v, input int nbits);
    set_line(inst, v);
    repeat (nbits * CPB) @(posedge comm_clk);
    #1;
  endtask

  task automatic send_frame(input int inst, input logic [7:0] d, input logic use_par,
                            input logic par_bit, input logic stop_val, input int idle_bits);
    hold_line(inst, 1'b0, 1);
    for (int i = 0; i < 8; i++) hold_line(inst, d[i], 1);
    if (use_par) hold_line(inst, par_bit, 1);
    hold_line(inst, stop_val, 1);
    hold_line(inst, 1'b1, idle_bits);
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    tests_run++;
    if (valid0 !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid0); end
    tests_run++;
    if (cnt0 !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    tests_run++;
    if (data0 !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", data0); end
    tests_run++;
    if ({fe0_p, pe0_p, ov0_p} !== 3'b000) begin tests_failed++; $display("FAIL reset_pulses: got %b want 000", {fe0_p, pe0_p, ov0_p}); end
    tests_run++;
    if (u_dut.state !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want IDLE", u_dut.state); end
    repeat (4) @(posedge comm_clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge comm_clk);
    #1;
    tests_run++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0) begin tests_failed++; $display("FAIL post_reset_valid: got %b%b want 00", valid0, valid1); end
  endtask

  task automatic test_basic();
    int f = fe0, p = pe0, o = ov0;
    logic [7:0] got;
    q0.delete();
    ready0 = 1'b1;
    send_frame(0, 8'h08, 1'b0, 1'b0, 1'b1, 2);
    got = (q0.size() > 0) ? q0[0] : 8'hxx;
    tests_run++;
    if (q0.size() != 1) begin tests_failed++; $display("FAIL basic_pops: got %0d want 1", q0.size()); end
    tests_run++;
    if (got !== 8'h08) begin tests_failed++; $display("FAIL basic_data: got %h want 08", got); end
    tests_run++;
    if (fe0 - f != 0 || pe0 - p != 0 || ov0 - o != 0) begin tests_failed++;
      $display("FAIL basic_errors: got fe=%0d pe=%0d ov=%0d want 0", fe0 - f, pe0 - p, ov0 - o); end
  endtask

  task automatic test_glitch();
    int f = fe0, p = pe0;
    q0.delete();
    line0 = 1'b0;
    repeat (5) @(posedge comm_clk);
    #1 line0 = 1'b1;
    hold_line(0, 1'b1, 3);
    tests_run++;
    if (q0.size() != 0 || cnt0 !== 3'd0) begin tests_failed++; $display("FAIL glitch_push: got pops=%0d count=%0d want 0", q0.size(), cnt0); end
    tests_run++;
    if (fe0 - f != 0 || pe0 - p != 0) begin tests_failed++; $display("FAIL glitch_errors: got fe=%0d pe=%0d want 0", fe0 - f, pe0 - p); end
    tests_run++;
    if (u_dut.state !== IDLE) begin tests_failed++; $display("FAIL glitch_state: got %0d want IDLE", u_dut.state); end
  endtask

  task automatic test_framing();
    int f = fe0, p = pe0;
    logic [7:0] got;
    q0.delete();
    ready0 = 1'b0;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 0);
    hold_line(0, 1'b0, 3);   // keep the line in break
    hold_line(0, 1'b1, 2);
    tests_run++;
    if (fe0 - f != 1) begin tests_failed++; $display("FAIL framing_pulses: got %0d want 1", fe0 - f); end
    tests_run++;
    if (cnt0 !== 3'd0) begin tests_failed++; $display("FAIL framing_count: got %0d want 0", cnt0); end
    tests_run++;
    if (pe0 - p != 0) begin tests_failed++; $display("FAIL framing_parity: got %0d want 0", pe0 - p); end
    ready0 = 1'b1;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 2);
    got = (q0.size() > 0) ? q0[0] : 8'hxx;
    tests_run++;
    if (q0.size() != 1 || got !== 8'h3C) begin tests_failed++; $display("FAIL framing_recover: got n=%0d data=%h want n=1 data=3c", q0.size(), got); end
  endtask

  task automatic test_parity();
    int p = pe1, f = fe1;
    logic [7:0] got;
    q1.delete();
    ready1 = 1'b1;
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 2);
    tests_run++;
    if (pe1 - p != 1) begin tests_failed++; $display("FAIL parity_pulse: got %0d want 1", pe1 - p); end
    tests_run++;
    if (q1.size() != 0) begin tests_failed++; $display("FAIL parity_discard: got %0d pops want 0", q1.size()); end
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 2);
    got = (q1.size() > 0) ? q1[0] : 8'hxx;
    tests_run++;
    if (q1.size() != 1 || got !== 8'h07) begin tests_failed++; $display("FAIL parity_good: got n=%0d data=%h want n=1 data=07", q1.size(), got); end
    tests_run++;
    if (pe1 - p != 1 || fe1 - f != 0) begin tests_failed++; $display("FAIL parity_errors: got pe=%0d fe=%0d want 1 0", pe1 - p, fe1 - f); end
  endtask

  task automatic test_overrun();
    int o = ov0;
    q0.delete();
    ready0 = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, 1);
    tests_run++;
    if (cnt0 !== 3'd4) begin tests_failed++; $display("FAIL overrun_count: got %0d want 4", cnt0); end
    tests_run++;
    if (ov0 - o != 1) begin tests_failed++; $display("FAIL overrun_pulse: got %0d want 1", ov0 - o); end
    repeat (10) @(posedge comm_clk);
    #1;
    tests_run++;
    if (valid0 !== 1'b1 || data0 !== 8'h01) begin tests_failed++; $display("FAIL overrun_hold: got v=%b d=%h want v=1 d=01", valid0, data0); end
    ready0 = 1'b1;
    repeat (8) @(posedge comm_clk);
    #1;
    tests_run++;
    if (q0.size() != 4) begin tests_failed++; $display("FAIL overrun_pops: got %0d want 4", q0.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] got;
      got = (q0.size() > i) ? q0[i] : 8'hxx;
      tests_run++;
      if (got !== 8'(i + 1)) begin tests_failed++; $display("FAIL overrun_order[%0d]: got %h want %h", i, got, 8'(i + 1)); end
    end
    tests_run++;
    if (cnt0 !== 3'd0) begin tests_failed++; $display("FAIL overrun_drain: got %0d want 0", cnt0); end
  endtask

  task automatic test_reset_mid_frame();
    int f = fe0;
    logic [7:0] got;
    q0.delete();
    ready0 = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1);
    tests_run++;
    if (valid0 !== 1'b1) begin tests_failed++; $display("FAIL midreset_setup: got %b want 1", valid0); end
    // Partial 0xFA: bits 3..7 are high, so no falling edge follows the reset.
    hold_line(0, 1'b0, 1);
    hold_line(0, 1'b0, 1);
    hold_line(0, 1'b1, 1);
    hold_line(0, 1'b0, 1);
    line0 = 1'b1;
    repeat (8) @(posedge comm_clk);
    #3 reset = 1'b1;
    #1;
    tests_run++;
    if (valid0 !== 1'b0 || cnt0 !== 3'd0 || data0 !== 8'h00) begin tests_failed++;
      $display("FAIL midreset_async: got v=%b n=%0d d=%h want 0 0 00", valid0, cnt0, data0); end
    repeat (3) @(posedge comm_clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge comm_clk);
    #1;
    hold_line(0, 1'b1, 6);
    tests_run++;
    if (cnt0 !== 3'd0 || fe0 - f != 0) begin tests_failed++; $display("FAIL midreset_partial: got n=%0d fe=%0d want 0 0", cnt0, fe0 - f); end
    ready0 = 1'b1;
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 2);
    got = (q0.size() > 0) ? q0[0] : 8'hxx;
    tests_run++;
    if (q0.size() != 1 || got !== 8'h5A) begin tests_failed++; $display("FAIL midreset_next: got n=%0d d=%h want n=1 d=5a", q0.size(), got); end
  endtask

  // Reference model: a frame with a low stop bit is a framing error; else a
  // parity mismatch (even parity) is a parity error; else the byte is delivered.
  task automatic test_random();
    logic [7:0] exp0[$], exp1[$];
    int fe_exp0 = 0, fe_exp1 = 0, pe_exp1 = 0;
    int f0 = fe0, f1 = fe1, p1 = pe1, o0 = ov0;
    q0.delete();
    q1.delete();
    ready0 = 1'b1;
    ready1 = 1'b1;
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d = 8'($urandom);
      logic stop = ($urandom_range(0, 4) != 0);
      if (!stop) fe_exp0++;
      else       exp0.push_back(d);
      send_frame(0, d, 1'b0, 1'b0, stop, 2);
    end
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d = 8'($urandom);
      logic p    = 1'($urandom_range(0, 1));
      logic stop = ($urandom_range(0, 4) != 0);
      if (!stop)          fe_exp1++;
      else if (p != ^d)   pe_exp1++;
      else                exp1.push_back(d);
      send_frame(1, d, 1'b1, p, stop, 2);
    end
    tests_run++;
    if (q0.size() != exp0.size()) begin tests_failed++; $display("FAIL rand0_count: got %0d want %0d", q0.size(), exp0.size()); end
    for (int i = 0; i < exp0.size(); i++) begin
      logic [7:0] got = (q0.size() > i) ? q0[i] : 8'hxx;
      tests_run++;
      if (got !== exp0[i]) begin tests_failed++; $display("FAIL rand0_data[%0d]: got %h want %h", i, got, exp0[i]); end
    end
    tests_run++;
    if (fe0 - f0 != fe_exp0 || ov0 - o0 != 0) begin tests_failed++; $display("FAIL rand0_errors: got fe=%0d ov=%0d want %0d 0", fe0 - f0, ov0 - o0, fe_exp0); end
    tests_run++;
    if (q1.size() != exp1.size()) begin tests_failed++; $display("FAIL rand1_count: got %0d want %0d", q1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size(); i++) begin
      logic [7:0] got = (q1.size() > i) ? q1[i] : 8'hxx;
      tests_run++;
      if (got !== exp1[i]) begin tests_failed++; $display("FAIL rand1_data[%0d]: got %h want %h", i, got, exp1[i]); end
    end
    tests_run++;
    if (fe1 - f1 != fe_exp1 || pe1 - p1 != pe_exp1) begin tests_failed++;
      $display("FAIL rand1_errors: got fe=%0d pe=%0d want %0d %0d", fe1 - f1, pe1 - p1, fe_exp1, pe_exp1); end
  endtask

  initial begin
    test_reset();
    @(posedge comm_clk);
    #1;
    test_basic();
    test_glitch();
    test_framing();
    test_parity();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
